stream_audio_ctrl: RTL and testbench

Parametrised successor to the single-channel UART-to-DAC audio path. It assembles little-endian multi-channel PCM frames from a received byte stream and buffers them in a frame FIFO. Frames are released at a fixed sample rate to the sigma-delta DACs. Adds start-threshold priming, underrun detection and counting, a partial-frame timeout, overflow flagging and hysteretic CTS flow control. It sits between rxuart and one fo_sigma_delta_dac per channel.

---
 rtl/stream_audio_ctrl_pkg.sv | 21 ++
 rtl/stream_frame_fifo.sv | 60 ++++++
 rtl/stream_audio_ctrl.sv | 167 ++++++++++++++++
 tb/tb_stream_audio_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_audio_ctrl_pkg.sv
// Shared definitions for the streaming audio path.
//   play_state_t    : playback state encoding (exported on the 2-bit state port)
//   midscale()      : DAC idle code for a given sample width
//   bytes_per_frame(): bytes the UART delivers per multi-channel frame
package stream_audio_ctrl_pkg;

  typedef enum logic [1:0] {
    PRIMING  = 2'd0,
    PLAYING  = 2'd1,
    UNDERRUN = 2'd2
  } play_state_t;

  function automatic logic [15:0] midscale(input int bits);
    return 16'(1) << (bits - 1);
  endfunction

  function automatic int bytes_per_frame(input int channels, input int bits);
    return channels * bits / 8;
  endfunction

endpackage

// File: rtl/stream_frame_fifo.sv
// Synchronous-RAM frame FIFO.
//   clk, reset     : clock, async active-high reset (discards contents)
//   push/push_data : write a frame; ignored while full
//   pop            : read a frame; ignored while empty
//   rd_data        : registered read data, valid the cycle after pop, holds
//                    otherwise; resets to RD_INIT
//   empty/full     : status
//   fill           : frames currently stored (0..DEPTH)
module stream_frame_fifo #(
  parameter int             W       = 32,
  parameter int             DEPTH   = 16,
  parameter logic [W-1:0]   RD_INIT = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (fill == '0);
  // DEPTH is a power of two, so the top fill bit is set only when full.
  assign full    = fill[AW];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      rd_data <= RD_INIT;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stream_audio_ctrl.sv
// UART byte stream to multi-channel sigma-delta DAC frame player.
//   clk, reset     : system clock, async active-high reset
//   rx_data/valid  : bytes from rxuart, little-endian samples, channel 0 first
//   sample_out     : current frame, channel n at [n*BITS +: BITS]
//   sample_ce      : one-cycle pulse when sample_out takes a new frame
//   dac_reset      : high whenever not PLAYING
//   cts            : hysteretic flow control to the sender
//   fill           : frames buffered
//   underrun_count : saturating underrun counter
//   overflow       : sticky, a complete frame was dropped on a full FIFO
//   state          : PRIMING / PLAYING / UNDERRUN
module stream_audio_ctrl
  import stream_audio_ctrl_pkg::*;
#(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int SAMPLE_RATE  = 11_025,
  parameter int BITS         = 16,
  parameter int CHANNELS     = 2,
  parameter int DEPTH        = 4096,
  parameter int START_LEVEL  = DEPTH / 2,
  parameter int LOW_MARK     = DEPTH / 10,
  parameter int HIGH_MARK    = DEPTH - DEPTH / 10,
  parameter int BYTE_TIMEOUT = 2000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [CHANNELS*BITS-1:0]     sample_out,
  output logic                         sample_ce,
  output logic                         dac_reset,
  output logic                         cts,
  output logic [$clog2(DEPTH):0]       fill,
  output logic [7:0]                   underrun_count,
  output logic                         overflow,
  output logic [1:0]                   state
);
  localparam int FW     = $clog2(DEPTH) + 1;
  localparam int W      = CHANNELS * BITS;
  localparam int BPF    = bytes_per_frame(CHANNELS, BITS);
  localparam int BIW    = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int PERIOD = CLK_FREQ / SAMPLE_RATE;
  localparam int TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int IW     = $clog2(BYTE_TIMEOUT + 1);

  localparam logic [FW-1:0]   START_F     = FW'(START_LEVEL);
  localparam logic [FW-1:0]   LOW_F       = FW'(LOW_MARK);
  localparam logic [FW-1:0]   HIGH_F      = FW'(HIGH_MARK);
  localparam logic [BIW-1:0]  LAST_IDX    = BIW'(BPF - 1);
  localparam logic [TW-1:0]   TICK_RELOAD = TW'(PERIOD - 1);
  localparam logic [IW-1:0]   TIMEOUT_I   = IW'(BYTE_TIMEOUT);
  localparam logic [BITS-1:0] MID         = BITS'(midscale(BITS));
  localparam logic [W-1:0]    MID_FRAME   = {CHANNELS{MID}};

  // ---------------- frame assembler ----------------
  // Byte k of a frame lands at bits [8k +: 8]: little-endian samples packed
  // channel 0 first make the frame a plain little-endian word.
  logic [BIW-1:0] byte_idx;
  logic [W-1:0]   frame_buf, frame_next;
  logic [IW-1:0]  idle_cnt;
  logic           push_q;
  logic           full, empty;

  always_comb begin
    frame_next = frame_buf;
    frame_next[{byte_idx, 3'b000} +: 8] = rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx  <= '0;
      frame_buf <= '0;
      idle_cnt  <= '0;
      push_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (rx_valid) begin
        idle_cnt  <= '0;
        frame_buf <= frame_next;
        if (byte_idx == LAST_IDX) begin
          byte_idx <= '0;
          push_q   <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end else if (idle_cnt != TIMEOUT_I) begin
        idle_cnt <= idle_cnt + 1'b1;
      end else if (byte_idx != '0) begin
        // Stale partial frame: realign to the next byte. The old bytes are
        // overwritten as the next frame assembles.
        byte_idx <= '0;
      end
    end
  end

  // ---------------- tick generator ----------------
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt <= TICK_RELOAD;
    else if (tick) tick_cnt <= TICK_RELOAD;
    else           tick_cnt <= tick_cnt - 1'b1;
  end

  // ---------------- playback FSM ----------------
  play_state_t st, st_next;
  logic        pop, pop_q;

  always_comb begin
    st_next = st;
    pop     = 1'b0;
    case (st)
      PRIMING:  if (fill >= START_F) st_next = PLAYING;
      PLAYING:  if (tick) begin
                  if (empty) st_next = UNDERRUN;
                  else       pop     = 1'b1;
                end
      UNDERRUN: st_next = PRIMING;
      default:  st_next = PRIMING;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st             <= PRIMING;
      pop_q          <= 1'b0;
      underrun_count <= '0;
      overflow       <= 1'b0;
      cts            <= 1'b1;
    end else begin
      st    <= st_next;
      // rd_data lands one cycle after pop, so the strobe is the delayed pop.
      pop_q <= pop;
      if (st == UNDERRUN && underrun_count != 8'hFF)
        underrun_count <= underrun_count + 1'b1;
      if (push_q && full)
        overflow <= 1'b1;
      if (fill >= HIGH_F)     cts <= 1'b0;
      else if (fill <= LOW_F) cts <= 1'b1;
    end
  end

  // rd_data resets to midscale and only moves on pop, so it is sample_out.
  stream_frame_fifo #(
    .W       (W),
    .DEPTH   (DEPTH),
    .RD_INIT (MID_FRAME)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (frame_buf),
    .pop       (pop),
    .rd_data   (sample_out),
    .empty     (empty),
    .full      (full),
    .fill      (fill)
  );

  assign sample_ce = pop_q;
  assign dac_reset = (st != PLAYING);
  assign state     = st;

endmodule

// File: tb/tb_stream_audio_ctrl.sv
module tb_stream_audio_ctrl;
  localparam logic [31:0] MIDF = 32'h8000_8000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] sample_out;
  logic        sample_ce, dac_reset, cts, overflow;
  logic [4:0]  fill;
  logic [7:0]  underrun_count;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;
  int ce_seen = 0;
  int cyc;
  logic [31:0] exp_q[$];
  bit          const_mode = 1'b0;
  logic [31:0] const_val = 32'h0;

  always #5 clk = ~clk;

  stream_audio_ctrl #(
    .CLK_FREQ(1000), .SAMPLE_RATE(100), .BITS(16), .CHANNELS(2), .DEPTH(16),
    .START_LEVEL(4), .LOW_MARK(2), .HIGH_MARK(14), .BYTE_TIMEOUT(50)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .sample_out(sample_out), .sample_ce(sample_ce), .dac_reset(dac_reset),
    .cts(cts), .fill(fill), .underrun_count(underrun_count),
    .overflow(overflow), .state(state)
  );

  // Clocks since reset release; tick fires when this is 9,19,... so a new
  // frame is visible when it is a multiple of 10.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && sample_ce) begin
      ce_seen++;
      check("ce_tick_phase", cyc % 10, 0);
      if (const_mode) check("sample_const", sample_out, const_val);
      else if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sample_unexpected: got 0x%0h expected no frame", sample_out);
      end else check("sample_frame", sample_out, exp_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f, input bit played);
    if (played) exp_q.push_back(f);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rx_data = f[i*8 +: 8]; rx_valid = 1'b1;
    end
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, input string name);
    int k = 0;
    while (state !== s && k < limit) begin @(negedge clk); k++; end
    if (state !== s) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout, state 0x%0h expected 0x%0h", name, state, s);
    end
  endtask

  task automatic wait_fill(input int v, input int limit, input string name);
    int k = 0;
    while (int'(fill) != v && k < limit) begin @(negedge clk); k++; end
    if (int'(fill) != v) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout, fill %0d expected %0d", name, fill, v);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sample_out"}, sample_out, MIDF);
    check({tag, "_sample_ce"}, 32'(sample_ce), 0);
    check({tag, "_dac_reset"}, 32'(dac_reset), 1);
    check({tag, "_cts"}, 32'(cts), 1);
    check({tag, "_fill"}, 32'(fill), 0);
    check({tag, "_underrun"}, 32'(underrun_count), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_state"}, 32'(state), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_vals("rst");

    // 1: one frame, stays priming
    send_frame(32'h5678_1234, 1);
    @(negedge clk);
    check("t1_fill", 32'(fill), 1);
    check("t1_state", 32'(state), 0);
    check("t1_dac_reset", 32'(dac_reset), 1);
    check("t1_sample_out", sample_out, MIDF);

    // 2: reach start level, play in order
    send_frame(32'h2222_1111, 1);
    send_frame(32'h4444_3333, 1);
    send_frame(32'h6666_5555, 1);
    @(negedge clk);
    check("t2_fill", 32'(fill), 4);
    @(negedge clk);
    check("t2_state", 32'(state), 1);
    check("t2_dac_reset", 32'(dac_reset), 0);

    // 3: drain into underrun
    wait_state(2'd2, 200, "t3_wait_underrun");
    check("t3_hold_sample", sample_out, 32'h6666_5555);
    check("t3_dac_reset", 32'(dac_reset), 1);
    check("t3_count_pre", 32'(underrun_count), 0);
    @(negedge clk);
    check("t3_state_priming", 32'(state), 0);
    check("t3_count", 32'(underrun_count), 1);
    check("t3_ce_seen", ce_seen, 4);
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: partial frame timeout
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    repeat (60) @(negedge clk);
    check("t4_no_push", 32'(fill), 0);
    send_frame(32'h0403_0201, 1);
    @(negedge clk);
    check("t4_fill", 32'(fill), 1);
    send_frame(32'hA1A2_A3A4, 1);
    send_frame(32'hB1B2_B3B4, 1);
    send_frame(32'hC1C2_C3C4, 1);
    wait_state(2'd2, 200, "t4_wait_underrun");
    @(negedge clk);
    check("t4_count", 32'(underrun_count), 2);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: fill up, cts hysteresis, overflow
    const_val  = 32'h0F0F_F0F0;
    const_mode = 1'b1;
    fork
      begin
        for (int i = 0; i < 50; i++) send_frame(const_val, 0);
      end
      begin
        int k = 0;
        while (int'(fill) < 14 && k < 400) begin @(negedge clk); k++; end
        check("t5_fill_high", 32'(fill), 14);
        check("t5_cts_before", 32'(cts), 1);
        @(negedge clk);
        check("t5_cts_low", 32'(cts), 0);
      end
    join
    @(negedge clk);
    check("t5_overflow", 32'(overflow), 1);
    check("t5_fill_full", 32'(int'(fill) >= 15 && int'(fill) <= 16), 1);
    check("t5_cts_held", 32'(cts), 0);
    wait_fill(2, 400, "t5_wait_drain");
    check("t5_cts_at_low", 32'(cts), 0);
    @(negedge clk);
    check("t5_cts_reassert", 32'(cts), 1);
    check("t5_overflow_sticky", 32'(overflow), 1);
    wait_state(2'd2, 200, "t5_wait_underrun");
    @(negedge clk);
    check("t5_count", 32'(underrun_count), 3);

    // 6: reset mid-frame and mid-playback
    const_mode = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(32'hC0DE_0000 + 32'(i), 1);
    send_byte(8'h99); send_byte(8'h88);
    check("t6_fill_nonzero", 32'(fill != 5'd0), 1);
    #2 reset = 1'b1;
    #1 check_reset_vals("t6_rst");
    exp_q.delete();
    @(negedge clk); reset = 1'b0;
    send_frame(32'hDEAD_BEEF, 1);
    @(negedge clk);
    check("t6_fill", 32'(fill), 1);
    send_frame(32'h1357_2468, 1);
    send_frame(32'h9ABC_DEF0, 1);
    send_frame(32'h0BAD_F00D, 1);
    wait_state(2'd2, 200, "t6_wait_underrun");
    @(negedge clk);
    check("t6_count", 32'(underrun_count), 1);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
